// File: rtl/tusca_pkg.sv
// Shared definitions for the DHT11 reader: FSM states, error codes and
// the byte layout of the 40-bit sensor frame.
package tusca_pkg;

  typedef enum logic [2:0] {
    OCIOSO,
    INICIO,
    ESPERA_RESP,
    RESP_BAIXO,
    RESP_ALTO,
    BIT_BAIXO,
    BIT_ALTO,
    VERIFICA
  } estado_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_TIMEOUT  = 2'b01,
    ERR_CHECKSUM = 2'b10
  } erro_tipo_t;

  localparam int N_BITS        = 40;
  localparam int BYTE_UMID_INT = 4;
  localparam int BYTE_UMID_DEC = 3;
  localparam int BYTE_TEMP_INT = 2;
  localparam int BYTE_TEMP_DEC = 1;
  localparam int BYTE_CHECKSUM = 0;

  // Byte 4 is the first byte on the wire and ends up in the top of the frame.
  function automatic logic [7:0] frame_byte(input logic [N_BITS-1:0] quadro, input int idx);
    return quadro[idx*8 +: 8];
  endfunction

endpackage

// File: rtl/gerador_tick_us.sv
// Free-running divider: one-cycle tick every CICLOS_US clocks, restarted by clear_i.
// Used for the microsecond timer and, in the auto-trigger build, the millisecond timer.
module gerador_tick_us #(
  parameter int CICLOS_US = 50
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int W = (CICLOS_US > 1) ? $clog2(CICLOS_US) : 1;
  localparam logic [W-1:0] ULTIMO = W'(CICLOS_US - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || cnt_q == ULTIMO) cnt_d = '0;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // Taken from the register only, so clear_i may depend on the consumer's FSM.
  assign tick_o = (cnt_q == ULTIMO);

endmodule

// File: rtl/dht11_leitor.sv
// DHT11 single-wire host: start pulse, 40-bit decode, checksum check.
// Optional periodic auto-trigger is enabled by defining DHT_AUTO_MEDIR_EN.
module dht11_leitor
  import tusca_pkg::*;
#(
  parameter int CICLOS_US      = 50,
  parameter int T_INICIO_US    = 18000,
  parameter int T_TIMEOUT_US   = 200,
  parameter int T_LIMIAR_US    = 50,
  parameter int PERIODO_MED_MS = 2000
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        medir_i,
  input  logic        dht_in_i,
  output logic        dht_oe_o,
  output logic [15:0] temp_o,
  output logic [15:0] umidade_o,
  output logic        pronto_o,
  output logic        erro_o,
  output logic [1:0]  erro_tipo_o,
  output logic        ocupado_o
);

  localparam int DUR_W = 16;
  localparam logic [DUR_W-1:0] T_INICIO_M1 = DUR_W'(T_INICIO_US - 1);
  localparam logic [DUR_W-1:0] T_TIMEOUT   = DUR_W'(T_TIMEOUT_US);
  localparam logic [DUR_W-1:0] T_LIMIAR    = DUR_W'(T_LIMIAR_US);

  if (CICLOS_US < 1 || T_LIMIAR_US >= T_TIMEOUT_US || PERIODO_MED_MS < 1) begin : g_parametros_invalidos
    $error("dht11_leitor: inconsistent timing parameters");
  end

  estado_t              estado_q, estado_d;
  erro_tipo_t           erro_tipo_q, erro_tipo_d;
  logic [5:0]           bit_cnt_q, bit_cnt_d;
  logic [N_BITS-1:0]    quadro_q, quadro_d;
  logic [15:0]          temp_q, temp_d, umid_q, umid_d;
  logic                 pronto_q, pronto_d, erro_q, erro_d;
  logic [DUR_W-1:0]     dur_q;
  logic                 sync1_q, sync2_q, prev_q;
  logic                 borda_desce, borda_sobe, tick_us, troca_estado;
  logic                 auto_medir, partida, estouro, espera_sensor;
  logic [7:0]           soma;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= dht_in_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign borda_desce  = prev_q & ~sync2_q;
  assign borda_sobe   = ~prev_q & sync2_q;
  assign troca_estado = (estado_d != estado_q);

  gerador_tick_us #(.CICLOS_US(CICLOS_US)) u_tick_us (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .clear_i (troca_estado),
    .tick_o  (tick_us)
  );

  // Microseconds spent in the current state; saturates instead of wrapping.
  always_ff @(posedge clock_i) begin
    if (reset_i || troca_estado)         dur_q <= '0;
    else if (tick_us && dur_q != '1)     dur_q <= dur_q + 1'b1;
  end

`ifdef DHT_AUTO_MEDIR_EN
  localparam int MS_W = (PERIODO_MED_MS > 1) ? $clog2(PERIODO_MED_MS) : 1;
  localparam logic [MS_W-1:0] PERIODO_M1 = MS_W'(PERIODO_MED_MS - 1);

  logic            tick_ms, ms_clear;
  logic [MS_W-1:0] ms_q;

  assign ms_clear = (estado_q != OCIOSO) || partida;

  gerador_tick_us #(.CICLOS_US(CICLOS_US * 1000)) u_tick_ms (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .clear_i (ms_clear),
    .tick_o  (tick_ms)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i || ms_clear) ms_q <= '0;
    else if (tick_ms)        ms_q <= ms_q + 1'b1;
  end

  assign auto_medir = tick_ms && (ms_q == PERIODO_M1) && (estado_q == OCIOSO);
`else
  assign auto_medir = 1'b0;
`endif

  // A request coinciding with the end-of-read pulse is dropped, not deferred.
  assign partida       = (medir_i || auto_medir) && !pronto_q && !erro_q;
  assign estouro       = (dur_q == T_TIMEOUT);
  assign espera_sensor = (estado_q == ESPERA_RESP) || (estado_q == RESP_BAIXO) ||
                         (estado_q == RESP_ALTO)   || (estado_q == BIT_BAIXO)  ||
                         (estado_q == BIT_ALTO);
  assign soma = frame_byte(quadro_q, BYTE_UMID_INT) + frame_byte(quadro_q, BYTE_UMID_DEC) +
                frame_byte(quadro_q, BYTE_TEMP_INT) + frame_byte(quadro_q, BYTE_TEMP_DEC);

  always_comb begin
    estado_d    = estado_q;
    erro_tipo_d = erro_tipo_q;
    bit_cnt_d   = bit_cnt_q;
    quadro_d    = quadro_q;
    temp_d      = temp_q;
    umid_d      = umid_q;
    pronto_d    = 1'b0;
    erro_d      = 1'b0;
    case (estado_q)
      OCIOSO: if (partida) begin
        estado_d    = INICIO;
        erro_tipo_d = ERR_NONE;
      end
      INICIO:      if (tick_us && dur_q == T_INICIO_M1) estado_d = ESPERA_RESP;
      ESPERA_RESP: if (borda_desce) estado_d = RESP_BAIXO;
      RESP_BAIXO:  if (borda_sobe)  estado_d = RESP_ALTO;
      RESP_ALTO: if (borda_desce) begin
        estado_d  = BIT_BAIXO;
        bit_cnt_d = '0;
      end
      BIT_BAIXO:   if (borda_sobe)  estado_d = BIT_ALTO;
      BIT_ALTO: if (borda_desce) begin
        quadro_d = {quadro_q[N_BITS-2:0], (dur_q >= T_LIMIAR)};
        if (bit_cnt_q == 6'(N_BITS - 1)) begin
          estado_d = VERIFICA;
        end else begin
          estado_d  = BIT_BAIXO;
          bit_cnt_d = bit_cnt_q + 6'd1;
        end
      end
      VERIFICA: begin
        estado_d = OCIOSO;
        if (soma == frame_byte(quadro_q, BYTE_CHECKSUM)) begin
          umid_d   = {frame_byte(quadro_q, BYTE_UMID_INT), frame_byte(quadro_q, BYTE_UMID_DEC)};
          temp_d   = {frame_byte(quadro_q, BYTE_TEMP_INT), frame_byte(quadro_q, BYTE_TEMP_DEC)};
          pronto_d = 1'b1;
        end else begin
          erro_d      = 1'b1;
          erro_tipo_d = ERR_CHECKSUM;
        end
      end
      default: estado_d = OCIOSO;
    endcase
    // An edge seen in the same cycle as the limit still counts.
    if (espera_sensor && estouro && estado_d == estado_q) begin
      estado_d    = OCIOSO;
      erro_d      = 1'b1;
      erro_tipo_d = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      estado_q    <= OCIOSO;
      erro_tipo_q <= ERR_NONE;
      bit_cnt_q   <= '0;
      quadro_q    <= '0;
      temp_q      <= '0;
      umid_q      <= '0;
      pronto_q    <= 1'b0;
      erro_q      <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      erro_tipo_q <= erro_tipo_d;
      bit_cnt_q   <= bit_cnt_d;
      quadro_q    <= quadro_d;
      temp_q      <= temp_d;
      umid_q      <= umid_d;
      pronto_q    <= pronto_d;
      erro_q      <= erro_d;
    end
  end

  assign dht_oe_o    = (estado_q == INICIO);
  assign ocupado_o   = (estado_q != OCIOSO);
  assign temp_o      = temp_q;
  assign umidade_o   = umid_q;
  assign pronto_o    = pronto_q;
  assign erro_o      = erro_q;
  assign erro_tipo_o = erro_tipo_q;

endmodule
